// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and data-memory signal bundle for dmem_arbiter
//
// Purpose: groups the two requester handshakes and the data-memory strobes so
// the arbiter and its environment connect through one port.
//
// Signals (direction as seen by the arbiter, modport slave):
//   m0_* / m1_*  requester ports (0 = core load/store unit, 1 = debug/DMA)
//     mN_req    in   request valid, held until mN_gnt
//     mN_we     in   1 = write, 0 = read
//     mN_addr   in   byte address
//     mN_wdata  in   write data
//     mN_gnt    out  command accepted this cycle (combinational)
//     mN_rvalid out  one-cycle response pulse
//     mN_rdata  out  read data, valid with mN_rvalid
//     mN_err    out  error flag, valid with mN_rvalid
//   MemRead     out  memory read strobe
//   MemWrite    out  memory write strobe
//   Address     out  memory byte address
//   write_data  out  memory write data
//   Read_Data   in   combinational read data from memory
//
// Modports: slave = arbiter side, master = requester/memory environment side.

interface dmem_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m0_err;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_err;

  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] write_data;
  logic [31:0] Read_Data;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  Read_Data,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output MemRead, MemWrite, Address, write_data
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output Read_Data,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  MemRead, MemWrite, Address, write_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and access sequencer for the data memory
//
// Purpose: shares the single-ported data memory (DEPTH_WORDS x 32-bit words
// at byte address BASE_ADDR) between the core load/store unit (port 0) and a
// debug/DMA master (port 1). A granted command strobes the memory for exactly
// one cycle and is answered with a registered one-cycle response on the
// winning port: grant in N, strobe in N+1, rvalid in N+2. A grant issued while
// a response is out overlaps it, giving one transaction every two cycles.
//
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-low reset (0 = reset asserted)
//   bus    dmem_arbiter_if.slave: requester handshakes and memory strobes
//
// Parameters:
//   BASE_ADDR    byte address of data memory word 0
//   DEPTH_WORDS  number of 32-bit words in the data memory
//
// Optional feature macro: DMEM_ARB_RANGE_CHECK_EN
//   defined   - a command whose address is outside the memory window or not
//               word aligned is flagged at grant; it strobes nothing and is
//               answered with err=1, rdata=0 on the usual schedule.
//   undefined - every command goes to memory; m0_err/m1_err stay 0.

module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam bit RANGE_CHECK_EN = 1'b1;
`else
  localparam bit RANGE_CHECK_EN = 1'b0;
`endif

  // One past the last valid byte address; 33 bits so a window touching the
  // top of the address space cannot wrap.
  localparam logic [32:0] LIMIT_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_winner_q, last_winner_d;
  logic        cmd_port_q, cmd_port_d;
  logic        cmd_we_q, cmd_we_d;
  logic        cmd_err_q, cmd_err_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  // Arbitration view of the current inputs.
  logic        any_req;
  logic        both_req;
  logic        winner;
  logic        grant;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        addr_bad;

  // Strobe/response qualifiers derived from the latched command.
  logic        mem_access;
  logic        resp_out;

  assign any_req  = bus.m0_req | bus.m1_req;
  assign both_req = bus.m0_req & bus.m1_req;

  // On a tie the port not served last wins; otherwise the lone requester
  // wins, which is port 1 exactly when m1_req is the one that is high.
  assign winner = both_req ? ~last_winner_q : bus.m1_req;

  assign win_we    = winner ? bus.m1_we    : bus.m0_we;
  assign win_addr  = winner ? bus.m1_addr  : bus.m0_addr;
  assign win_wdata = winner ? bus.m1_wdata : bus.m0_wdata;

  assign addr_bad = (win_addr < BASE_ADDR)
                 || ({1'b0, win_addr} >= LIMIT_ADDR)
                 || (win_addr[1:0] != 2'b00);

  always_comb begin : fsm_comb
    state_d       = state_q;
    last_winner_d = last_winner_q;
    cmd_port_d    = cmd_port_q;
    cmd_we_d      = cmd_we_q;
    cmd_err_d     = cmd_err_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_wdata_d   = cmd_wdata_q;
    rsp_data_d    = rsp_data_q;

    // Arbitration is open in IDLE and RESP; ACCESS owns the memory. Reset is
    // folded in so no grant is shown while reset is held.
    grant = reset & (state_q != ACCESS) & any_req;

    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESP;
        // Writes and flagged commands answer with zero data.
        rsp_data_d = (!cmd_we_q && !cmd_err_q) ? bus.Read_Data : 32'd0;
      end
      RESP: begin
        state_d = grant ? ACCESS : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A grant in RESP overwrites the command while the previous response is
    // still on the outputs; that response reads only rsp_data_q and the
    // command registers' old values, which change at the end of this cycle.
    if (grant) begin
      last_winner_d = winner;
      cmd_port_d    = winner;
      cmd_we_d      = win_we;
      cmd_addr_d    = win_addr;
      cmd_wdata_d   = win_wdata;
      cmd_err_d     = RANGE_CHECK_EN & addr_bad;
    end

    bus.m0_gnt = grant & ~winner;
    bus.m1_gnt = grant & winner;

    // Strobes exist only in ACCESS, so an asynchronous reset (which forces
    // IDLE) drops them at once and the aborted command never responds.
    mem_access   = (state_q == ACCESS) & ~cmd_err_q;
    bus.MemRead  = mem_access & ~cmd_we_q;
    bus.MemWrite = mem_access & cmd_we_q;

    bus.Address    = cmd_addr_q;
    bus.write_data = cmd_wdata_q;

    resp_out      = (state_q == RESP);
    bus.m0_rvalid = resp_out & ~cmd_port_q;
    bus.m1_rvalid = resp_out & cmd_port_q;
    bus.m0_rdata  = bus.m0_rvalid ? rsp_data_q : 32'd0;
    bus.m1_rdata  = bus.m1_rvalid ? rsp_data_q : 32'd0;
    bus.m0_err    = bus.m0_rvalid & cmd_err_q;
    bus.m1_err    = bus.m1_rvalid & cmd_err_q;
  end

  always_ff @(posedge clk or negedge reset) begin : fsm_seq
    if (!reset) begin
      state_q       <= IDLE;
      // Port 1 counts as served last so port 0 wins the first tie.
      last_winner_q <= 1'b1;
      cmd_port_q    <= 1'b0;
      cmd_we_q      <= 1'b0;
      cmd_err_q     <= 1'b0;
      cmd_addr_q    <= 32'd0;
      cmd_wdata_q   <= 32'd0;
      rsp_data_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      cmd_port_q    <= cmd_port_d;
      cmd_we_q      <= cmd_we_d;
      cmd_err_q     <= cmd_err_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_wdata_q   <= cmd_wdata_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a transaction-level model

module tb_dmem_arbiter;

`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .BASE_ADDR  (32'd1024),
    .DEPTH_WORDS(256)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int cmp_total = 0, cmp_bad = 0;
  int lit_total = 0, lit_bad = 0;

  function automatic bit in_range(input logic [31:0] a);
    return (a >= 32'd1024) && (a < 32'd2048);
  endfunction

  function automatic logic [7:0] widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return off[9:2];
  endfunction

  // Memory attached to the arbiter; preload port used only while in reset.
  logic [31:0] ram [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_data = 32'd0;

  assign bus.Read_Data = in_range(bus.Address) ? ram[widx(bus.Address)] : 32'h0BAD0BAD;

  always @(posedge clk) begin
    if (pl_en) ram[pl_idx] <= pl_data;
    else if (bus.MemWrite && in_range(bus.Address)) ram[widx(bus.Address)] <= bus.write_data;
  end

  // Transaction-level model: a granted command occupies the memory in the
  // next cycle and is answered in the one after that.
  logic [31:0] model_mem [0:255];
  bit          acc_v = 0, acc_port = 0, acc_we = 0, acc_err = 0;
  logic [31:0] acc_addr = 0, acc_wdata = 0;
  bit          rsp_v = 0, rsp_port = 0, rsp_err = 0;
  logic [31:0] rsp_data = 0;
  bit          last = 1;
  logic [31:0] lat_addr = 0, lat_wdata = 0;

  task automatic mchk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_total++;
    if (act !== exp) begin
      cmp_bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic pchk(input string name, input logic [31:0] act, input logic [31:0] exp);
    lit_total++;
    if (act !== exp) begin
      lit_bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : model
    bit any, win, g;
    if (pl_en) model_mem[pl_idx] = pl_data;
    if (!reset) begin
      mchk("rst_m0_gnt", bus.m0_gnt, 0);
      mchk("rst_m1_gnt", bus.m1_gnt, 0);
      mchk("rst_m0_rvalid", bus.m0_rvalid, 0);
      mchk("rst_m1_rvalid", bus.m1_rvalid, 0);
      mchk("rst_m0_err", bus.m0_err, 0);
      mchk("rst_m1_err", bus.m1_err, 0);
      mchk("rst_m0_rdata", bus.m0_rdata, 0);
      mchk("rst_m1_rdata", bus.m1_rdata, 0);
      mchk("rst_MemRead", bus.MemRead, 0);
      mchk("rst_MemWrite", bus.MemWrite, 0);
      mchk("rst_Address", bus.Address, 0);
      mchk("rst_write_data", bus.write_data, 0);
      acc_v = 0; rsp_v = 0; last = 1; lat_addr = 0; lat_wdata = 0;
    end else begin
      any = bus.m0_req || bus.m1_req;
      win = (bus.m0_req && bus.m1_req) ? !last : bus.m1_req;
      g   = any && !acc_v;
      mchk("m0_gnt", bus.m0_gnt, g && !win);
      mchk("m1_gnt", bus.m1_gnt, g && win);
      mchk("MemRead", bus.MemRead, acc_v && !acc_we && !acc_err);
      mchk("MemWrite", bus.MemWrite, acc_v && acc_we && !acc_err);
      mchk("Address", bus.Address, lat_addr);
      mchk("write_data", bus.write_data, lat_wdata);
      mchk("m0_rvalid", bus.m0_rvalid, rsp_v && !rsp_port);
      mchk("m1_rvalid", bus.m1_rvalid, rsp_v && rsp_port);
      if (rsp_v && !rsp_port) begin
        mchk("m0_rdata", bus.m0_rdata, rsp_data);
        mchk("m0_err", bus.m0_err, rsp_err);
      end
      if (rsp_v && rsp_port) begin
        mchk("m1_rdata", bus.m1_rdata, rsp_data);
        mchk("m1_err", bus.m1_err, rsp_err);
      end
      rsp_v    = acc_v;
      rsp_port = acc_port;
      rsp_err  = acc_err;
      if (acc_we || acc_err) rsp_data = 0;
      else rsp_data = in_range(acc_addr) ? model_mem[widx(acc_addr)] : 32'h0BAD0BAD;
      if (acc_v && acc_we && !acc_err && in_range(acc_addr)) model_mem[widx(acc_addr)] = acc_wdata;
      acc_v = g;
      if (g) begin
        acc_port  = win;
        acc_we    = win ? bus.m1_we : bus.m0_we;
        acc_addr  = win ? bus.m1_addr : bus.m0_addr;
        acc_wdata = win ? bus.m1_wdata : bus.m0_wdata;
        acc_err   = RC && ((acc_addr < 32'd1024) || (acc_addr >= 32'd2048) || (acc_addr[1:0] != 2'b00));
        last      = win;
        lat_addr  = acc_addr;
        lat_wdata = acc_wdata;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command from posedge+1 and holds it until granted; returns at
  // posedge+1 of the cycle after the grant (the strobe cycle).
  task automatic issue(input int p, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, output int gcyc);
    bit done;
    done = 0;
    gcyc = -1;
    if (p == 0) begin
      bus.m0_req = 1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end else begin
      bus.m1_req = 1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      if ((p == 0) ? bus.m0_gnt : bus.m1_gnt) begin
        gcyc = cyc;
        done = 1;
      end
      @(posedge clk);
      #1;
      if (done) begin
        if (p == 0) bus.m0_req = 0; else bus.m1_req = 0;
      end
    end
    if (!done) begin
      lit_total++;
      lit_bad++;
      $display("FAIL grant_timeout port=%0d got=none want=gnt", p);
      bus.m0_req = 0;
      bus.m1_req = 0;
    end
  endtask

  int gcyc, rel_cyc;
  int gport [$];
  int gtime [$];

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;

    for (int i = 0; i < 256; i++) begin
      step();
      pl_en   = 1'b1;
      pl_idx  = i[7:0];
      pl_data = (i == 0) ? 32'hDEADBEEF : {24'hC0FFEE, i[7:0]};
    end
    step();
    pl_en = 1'b0;

    // A request held during reset must not be granted.
    bus.m0_req = 1;
    #1;
    pchk("reset_no_gnt", bus.m0_gnt, 0);
    pchk("reset_no_read", bus.MemRead, 0);
    step();
    bus.m0_req = 0;

    // Single read of word 0.
    reset = 1'b1;
    rel_cyc = cyc;
    issue(0, 1'b0, 32'd1024, 32'd0, gcyc);
    pchk("first_grant_cycle", gcyc, rel_cyc);
    pchk("read_MemRead", bus.MemRead, 1);
    pchk("read_Address", bus.Address, 32'd1024);
    step();
    pchk("read_rvalid", bus.m0_rvalid, 1);
    pchk("read_rdata", bus.m0_rdata, 32'hDEADBEEF);
    step();
    pchk("read_rvalid_done", bus.m0_rvalid, 0);

    // m1 writes then reads back word 1.
    issue(1, 1'b1, 32'd1028, 32'h12345678, gcyc);
    pchk("write_MemWrite", bus.MemWrite, 1);
    pchk("write_MemRead", bus.MemRead, 0);
    pchk("write_data", bus.write_data, 32'h12345678);
    step();
    pchk("write_rvalid", bus.m1_rvalid, 1);
    pchk("write_landed", ram[1], 32'h12345678);
    issue(1, 1'b0, 32'd1028, 32'd0, gcyc);
    step();
    pchk("readback_rdata", bus.m1_rdata, 32'h12345678);

    // Out-of-window and misaligned reads.
    issue(0, 1'b0, 32'd2048, 32'd0, gcyc);
    pchk("oor_MemRead", bus.MemRead, RC ? 0 : 1);
    step();
    pchk("oor_err", bus.m0_err, RC ? 1 : 0);
    pchk("oor_rdata", bus.m0_rdata, RC ? 32'd0 : 32'h0BAD0BAD);
    issue(0, 1'b0, 32'd1026, 32'd0, gcyc);
    pchk("misal_MemRead", bus.MemRead, RC ? 0 : 1);
    step();
    pchk("misal_err", bus.m0_err, RC ? 1 : 0);
    pchk("misal_rdata", bus.m0_rdata, RC ? 32'd0 : 32'hDEADBEEF);
    step();

    // m1 request pulsed only during m0's strobe cycle is never granted.
    issue(0, 1'b0, 32'd1024, 32'd0, gcyc);
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'd1032; bus.m1_wdata = 32'hFFFFFFFF;
    #1;
    pchk("withdraw_no_gnt_a", bus.m1_gnt, 0);
    step();
    bus.m1_req = 0;
    #1;
    pchk("withdraw_no_gnt_b", bus.m1_gnt, 0);
    pchk("withdraw_m0_rvalid", bus.m0_rvalid, 1);
    step();
    step();
    pchk("withdraw_no_write", ram[2], 32'hC0FFEE02);

    // Reset during a write's strobe cycle aborts it.
    issue(0, 1'b1, 32'd1044, 32'h55AA55AA, gcyc);
    pchk("abort_MemWrite_before", bus.MemWrite, 1);
    #2;
    reset = 1'b0;
    #1;
    pchk("abort_MemWrite_drop", bus.MemWrite, 0);
    pchk("abort_Address", bus.Address, 0);
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'd1024; bus.m0_wdata = 0;
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'd1040; bus.m1_wdata = 32'hA5A50000;
    step();
    pchk("abort_no_rvalid", bus.m0_rvalid, 0);
    pchk("abort_not_written", ram[5], 32'hC0FFEE05);
    step();

    // Both ports request continuously from reset release.
    reset = 1'b1;
    rel_cyc = cyc;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (bus.m0_gnt) begin gport.push_back(0); gtime.push_back(cyc); end
      if (bus.m1_gnt) begin gport.push_back(1); gtime.push_back(cyc); end
      step();
    end
    bus.m0_req = 0;
    bus.m1_req = 0;
    pchk("contend_grants", gport.size(), 4);
    if (gport.size() == 4) begin
      pchk("contend_first_cycle", gtime[0], rel_cyc);
      for (int i = 0; i < 4; i++) begin
        pchk("contend_port", gport[i], i % 2);
        pchk("contend_spacing", gtime[i] - gtime[0], 2 * i);
      end
    end
    step();
    step();
    step();

    $display("test done: total=%0d bad=%0d", cmp_total + lit_total, cmp_bad + lit_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-ported data memory (256 x 32-bit words mapped at byte address 1024). It shares the memory between the core load/store unit (port 0) and a debug/DMA master (port 1). It accepts one request per transaction with a grant handshake and arbitrates round-robin. It drives the memory's MemRead/MemWrite/Address/write_data strobes for exactly one cycle, then returns registered read data and an acknowledge to the winning requester.

## Interface
- BASE_ADDR, 32'd1024: byte address of data memory word 0.
- DEPTH_WORDS, 256: number of 32-bit words in the data memory.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- m0_req / m1_req  in  1  request valid; held until grant.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_gnt / m1_gnt  out  1  combinational; command accepted this cycle.
- m0_rvalid / m1_rvalid  out  1  one-cycle response pulse.
- m0_rdata / m1_rdata  out  32  read data, valid with rvalid.
- m0_err / m1_err  out  1  error flag, valid with rvalid.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- Address  out  32  memory byte address.
- write_data  out  32  memory write data.
- Read_Data  in  32  combinational read data from memory.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- Arbitration runs in IDLE and RESP:
  - If any mN_req is high, one winner is selected and its mN_gnt is asserted.
  - The winner's we/addr/wdata and its port id are latched, and the FSM goes to ACCESS.
  - If no request is high: IDLE stays in IDLE, and RESP goes to IDLE.
- Round-robin:
  - A last_winner register holds the port served last.
  - With both requests high, the port that is not last_winner wins.
  - With a single request, that port wins.
  - last_winner is updated at grant; its reset value is 1, so port 0 wins the first tie.
- ACCESS (exactly one cycle):
  - Asserts MemRead (read) or MemWrite (write) from the latched command.
  - For reads, Read_Data is captured into the response register at the end of the cycle.
  - Next state is always RESP.
- RESP:
  - Pulses rvalid on the latched port only.
  - rdata = captured data for reads, 0 for writes.
  - err = 0, unless the range check (see Configuration) flags the access.
- Address/write_data are always driven from the latched command.
- MemRead and MemWrite are never high simultaneously, and never high outside ACCESS.
- Requesters must hold req/we/addr/wdata stable until gnt. Dropping req before gnt withdraws the request legally.

## Timing
- Grant in cycle N → memory strobe in N+1 → rvalid in N+2.
- Write lands in memory at the rising edge ending cycle N+1.
- Back-to-back throughput: one transaction per 2 cycles, because a grant issued in RESP overlaps the previous response.
- Reset asserted (reset=0), effective immediately and asynchronously:
  - FSM goes to IDLE, and last_winner goes to 1.
  - All gnt, rvalid, err, MemRead and MemWrite go to 0.
  - rdata, Address and write_data go to 0.
- Reset asserted mid-ACCESS: the strobe drops immediately. No response is issued for the aborted transaction.
- First grant is possible in the first cycle after reset deasserts.
- Simultaneous events:
  - Both requests arriving in the same cycle are resolved by round-robin.
  - A new grant in RESP coincides with rvalid of the previous transaction. This is legal even when the new grant and the rvalid are on the same port.

## Configuration
- DMEM_ARB_RANGE_CHECK_EN defined:
  - At grant, an address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) or with addr[1:0] != 0 is flagged.
  - A flagged transaction asserts no MemRead/MemWrite in its ACCESS cycle.
  - Its RESP has err=1 and rdata=0.
  - Timing is unchanged.
- DMEM_ARB_RANGE_CHECK_EN undefined:
  - No check; every access is forwarded to memory.
  - m0_err and m1_err are tied to 0.

## Test plan
- Single read: reset, preload word 0 = 32'hDEADBEEF, m0 reads addr 1024.
  - Required: m0_gnt at N, MemRead=1 with Address=1024 at N+1, m0_rvalid with m0_rdata=32'hDEADBEEF at N+2.
- Write then read: m1 writes 32'h12345678 to 1028, then reads 1028.
  - Required: MemWrite pulse at N+1, and the read returns 32'h12345678.
- Contention: both ports request continuously from reset.
  - Required: grants alternate m0, m1, m0, m1.
  - Required: each grant is spaced 2 cycles apart, and no port is starved.
- Range check enabled: m0 reads 2048, then m0 reads 1026.
  - Required: no MemRead on either access.
  - Required: m0_err=1 and m0_rdata=0 on both responses.
  - With the macro undefined, the same accesses give err=0 and the memory is strobed.
- Reset mid-ACCESS: assert reset=0 during a write's ACCESS cycle.
  - Required: MemWrite drops asynchronously, no rvalid follows, and the FSM is in IDLE.
  - Required: after release, m0 wins the first tie.
- Withdrawn request: m1_req is pulsed for 1 cycle while m0 is being served.
  - Required: no m1_gnt, and the memory sees only m0 traffic.
